crane_ctrl_gen: RTL and testbench
=================================

Name: crane_ctrl_gen

Overview:
Parametrised Moore controller for one crane/manipulator pick cycle. It accepts a job over a valid/ready handshake, giving a target angle and a pick height. It then rotates by the shortest path, lowers, waits for hook, raises, waits for unhook, settles to start height and rotates home. Generalises the fixed 2-bit-angle controller with these additions:
- configurable widths and limits
- bidirectional rotation
- per-job pick height
- wait timeouts
- abort

It sits between the operator command interface and the hoist/slew actuator decoder.

Parameters:
ANGLE_W, 2, angle bus width; positions 0..2^ANGLE_W-1, wrap-around
HEIGHT_W, 3, height bus width
TURN_TIME, 3, cycles per one-step slew (>=1)
UP_TO, 3, carry height after hook
START_H, 2, parking/travel height
HOME_ANGLE, 0, home slew position
WAIT_MAX, 15, cycles allowed in WAIT_HOOK or WAIT_UNHOOK before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_angle  in  ANGLE_W  target slew position
cmd_height  in  HEIGHT_W  pick height
hooked  in  1  load engaged
unhooked  in  1  load released
abort  in  1  cancel job before pickup
angle_out  out  ANGLE_W  current slew position
height_out  out  HEIGHT_W  current hook height
action  out  3  actuator code
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on return to IDLE
err_timeout  out  1  one-cycle pulse on wait timeout

Behaviour:
- Reset (async, any state, mid-job included):
  - state=IDLE, angle_out=HOME_ANGLE, height_out=START_H, action=NOTHING
  - done=0, err_timeout=0; all counters 0; latched job cleared
- Action codes: DN=0, A1=1, UP=2, A2=3, R1=4, R2=5, NOTHING=6, TURN=7.
- All outputs are registered, Moore style.
- IDLE:
  - action=NOTHING.
  - cmd_valid&cmd_ready at edge N: latch cmd_angle and cmd_height; state TURN_OUT from N+1.
  - cmd_height is clamped to UP_TO if larger.
- TURN_OUT:
  - action=TURN.
  - Direction = shortest modular distance from angle_out to target. Equal distance (half-turn) -> increment.
  - turn counter counts 0..TURN_TIME-1. At TURN_TIME-1 the counter clears and angle_out steps ±1 with wrap (max+1=0, 0-1=max).
  - When angle_out==target (checked every cycle, including on entry) -> LOWER, counter cleared.
- LOWER:
  - action=DN.
  - height_out moves one unit per cycle toward the latched pick height. Moves up if the pick height is above current.
  - Equal -> WAIT_HOOK.
- WAIT_HOOK:
  - action=A1; wait counter increments.
  - hooked -> RAISE.
  - Counter reaching WAIT_MAX -> err_timeout pulse, then SETTLE (job dropped, no load).
  - hooked has priority over timeout in the same cycle.
- RAISE:
  - action=UP; height_out +1 per cycle until UP_TO.
  - Then WAIT_UNHOOK with wait counter cleared.
- WAIT_UNHOOK:
  - action=A2.
  - unhooked -> SETTLE.
  - On WAIT_MAX: err_timeout pulses once, state holds, counter saturates, no further pulse. A loaded crane never moves unattended.
- SETTLE:
  - action=R1; height_out moves ±1 per cycle toward START_H.
  - Equal -> TURN_HOME, with action=R2 for that one transition cycle.
- TURN_HOME:
  - action=TURN; same slew rules as TURN_OUT, toward HOME_ANGLE.
  - Arrival -> IDLE, done=1 for one cycle, action=NOTHING.
- abort:
  - Sampled in TURN_OUT, LOWER and WAIT_HOOK only; goes to SETTLE next cycle and clears the turn counter.
  - Ignored in all other states.
  - abort and hooked in the same WAIT_HOOK cycle -> abort wins.
- cmd_valid outside IDLE: ignored, no queuing.
- Width rules:
  - Angle arithmetic is modulo 2^ANGLE_W.
  - Height never wraps: clamp at 0 and at 2^HEIGHT_W-1.
  - Wait counter width is clog2(WAIT_MAX+1).

Decomposition:
- Package crane_pkg:
  - action code localparams/enum
  - state enum
  - shortest-direction function (ANGLE_W generic)
- One sub-module: crane_slew, containing:
  - turn counter
  - direction decision
  - angle register with wrap
  - go/at_target/step interface
- The FSM, height register and wait counter stay in crane_ctrl_gen.

Test Plan:
- Reset mid-RAISE (height 2->3): angle_out=0, height_out=2, action=6, busy=0 on the reset edge asynchronously.
- Defaults, cmd_angle=2, cmd_height=1, hooked at WAIT_HOOK+2, unhooked at WAIT_UNHOOK+1:
  - angle 0->1->2, each step after 3 cycles
  - height 2->1, then 1->2->3, then back to 2
  - angle 2->3->0 (half-turn ties increment; home via wrap); done pulses exactly once
  - action sequence 7,0,1,2,3,4,5,7,6
- ANGLE_W=3, cmd_angle=7: slew decrements 0->7 in one step (3 cycles), home return increments 7->0.
- WAIT_HOOK with no hooked for 15 cycles: err_timeout one pulse, SETTLE, home, done pulse; angle_out returns to 0.
- WAIT_UNHOOK timeout: single err_timeout pulse, state holds with action=3 for 40 cycles; a later unhooked resumes SETTLE normally.
- abort during TURN_OUT at angle 1: next cycle action=4, return to home, done; abort during RAISE ignored; cmd_valid during busy not accepted (cmd_ready=0).

Source files
------------

// File: rtl/crane_pkg.sv
// Shared types for the crane pick-cycle controller: actuator codes, FSM states,
// the per-state actuator decode and the shortest-slew direction helper.
package crane_pkg;

    typedef enum logic [2:0] {
        ACT_DN      = 3'd0,
        ACT_A1      = 3'd1,
        ACT_UP      = 3'd2,
        ACT_A2      = 3'd3,
        ACT_R1      = 3'd4,
        ACT_R2      = 3'd5,
        ACT_NOTHING = 3'd6,
        ACT_TURN    = 3'd7
    } action_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN_OUT,
        S_LOWER,
        S_WAIT_HOOK,
        S_RAISE,
        S_WAIT_UNHOOK,
        S_SETTLE,
        S_TURN_HOME
    } state_e;

    function automatic action_e state_action(input state_e s);
        action_e a;
        a = ACT_NOTHING;
        case (s)
            S_IDLE:                  a = ACT_NOTHING;
            S_TURN_OUT, S_TURN_HOME: a = ACT_TURN;
            S_LOWER:                 a = ACT_DN;
            S_WAIT_HOOK:             a = ACT_A1;
            S_RAISE:                 a = ACT_UP;
            S_WAIT_UNHOOK:           a = ACT_A2;
            S_SETTLE:                a = ACT_R1;
        endcase
        return a;
    endfunction

    // Forward distance no larger than half a turn means incrementing is shortest;
    // an exact half-turn therefore resolves to increment.
    function automatic logic shortest_inc(input logic [31:0] cur, input logic [31:0] tgt,
                                          input int unsigned width);
        logic [31:0] mask;
        logic [31:0] fwd;
        mask = (32'd1 << width) - 32'd1;
        fwd  = (tgt - cur) & mask;
        return fwd <= (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/crane_slew.sv
// Slew axis: angle register with modular wrap, per-step dwell counter and
// shortest-direction choice toward the requested target.
module crane_slew
    import crane_pkg::*;
#(
    parameter int ANGLE_W    = 2,
    parameter int TURN_TIME  = 3,
    parameter int HOME_ANGLE = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_go,
    input  logic [ANGLE_W-1:0] i_target,
    output logic [ANGLE_W-1:0] o_angle,
    output logic               o_at_target
);

    localparam int CNT_W = $clog2(TURN_TIME + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_TIME - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [ANGLE_W-1:0] r_angle;
    logic               w_inc;

    assign o_angle     = r_angle;
    assign o_at_target = (r_angle == i_target);
    assign w_inc       = shortest_inc(32'(r_angle), 32'(i_target), ANGLE_W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_angle <= ANGLE_W'(HOME_ANGLE);
            r_cnt   <= '0;
        end else if (!i_go || o_at_target) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_angle <= w_inc ? r_angle + 1'b1 : r_angle - 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/crane_ctrl_gen.sv
// Moore controller for one crane pick cycle: accept job, slew out, lower, hook,
// raise, unhook, settle and slew home, with wait timeouts and pre-pickup abort.
module crane_ctrl_gen
    import crane_pkg::*;
#(
    parameter int ANGLE_W    = 2,
    parameter int HEIGHT_W   = 3,
    parameter int TURN_TIME  = 3,
    parameter int UP_TO      = 3,
    parameter int START_H    = 2,
    parameter int HOME_ANGLE = 0,
    parameter int WAIT_MAX   = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [ANGLE_W-1:0]  i_cmd_angle,
    input  logic [HEIGHT_W-1:0] i_cmd_height,
    input  logic                i_hooked,
    input  logic                i_unhooked,
    input  logic                i_abort,
    output logic [ANGLE_W-1:0]  o_angle_out,
    output logic [HEIGHT_W-1:0] o_height_out,
    output logic [2:0]          o_action,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_timeout
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0]   WAIT_TOP  = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [HEIGHT_W-1:0] H_UP      = HEIGHT_W'(UP_TO);
    localparam logic [HEIGHT_W-1:0] H_START   = HEIGHT_W'(START_H);

    state_e              r_state, w_next;
    action_e             r_action, w_action;
    logic [ANGLE_W-1:0]  r_job_angle, w_target;
    logic [HEIGHT_W-1:0] r_job_height, r_height, w_height, w_cmd_h;
    logic [WAIT_W-1:0]   r_wait, w_wait;
    logic                r_busy, r_ready, r_done, r_err;
    logic                w_go, w_at_target, w_done, w_err;

    function automatic logic [HEIGHT_W-1:0] f_toward(input logic [HEIGHT_W-1:0] cur,
                                                     input logic [HEIGHT_W-1:0] tgt);
        return (cur < tgt) ? cur + 1'b1 : cur - 1'b1;
    endfunction

    crane_slew #(
        .ANGLE_W   (ANGLE_W),
        .TURN_TIME (TURN_TIME),
        .HOME_ANGLE(HOME_ANGLE)
    ) u_slew (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_go       (w_go),
        .i_target   (w_target),
        .o_angle    (o_angle_out),
        .o_at_target(w_at_target)
    );

    assign w_cmd_h = (i_cmd_height > H_UP) ? H_UP : i_cmd_height;

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_next   = r_state;
        w_height = r_height;
        w_wait   = '0;
        w_go     = 1'b0;
        w_target = r_job_angle;
        w_done   = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: if (i_cmd_valid) w_next = S_TURN_OUT;
            S_TURN_OUT: begin
                if (i_abort)          w_next = S_SETTLE;
                else if (w_at_target) w_next = S_LOWER;
                else                  w_go   = 1'b1;
            end
            S_LOWER: begin
                if (i_abort)                        w_next   = S_SETTLE;
                else if (r_height == r_job_height)  w_next   = S_WAIT_HOOK;
                else                                w_height = f_toward(r_height, r_job_height);
            end
            S_WAIT_HOOK: begin
                if (i_abort)       w_next = S_SETTLE;
                else if (i_hooked) w_next = S_RAISE;
                else if (r_wait == WAIT_LAST) begin
                    w_next = S_SETTLE;
                    w_err  = 1'b1;
                end else           w_wait = r_wait + 1'b1;
            end
            S_RAISE: begin
                if (r_height < H_UP) w_height = r_height + 1'b1;
                else                 w_next   = S_WAIT_UNHOOK;
            end
            S_WAIT_UNHOOK: begin
                // A loaded hook only ever leaves on unhooked; the timeout just reports.
                if (i_unhooked)            w_next = S_SETTLE;
                else if (r_wait == WAIT_TOP) w_wait = r_wait;
                else begin
                    w_wait = r_wait + 1'b1;
                    w_err  = (r_wait == WAIT_LAST);
                end
            end
            S_SETTLE: begin
                if (r_height == H_START) w_next   = S_TURN_HOME;
                else                     w_height = f_toward(r_height, H_START);
            end
            S_TURN_HOME: begin
                w_target = ANGLE_W'(HOME_ANGLE);
                if (w_at_target) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else w_go = 1'b1;
            end
        endcase
        w_action = state_action(w_next);
        if (r_state == S_SETTLE && w_next == S_TURN_HOME) w_action = ACT_R2;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_height     <= H_START;
            r_wait       <= '0;
            r_job_angle  <= '0;
            r_job_height <= '0;
            r_action     <= ACT_NOTHING;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_height <= w_height;
            r_wait   <= w_wait;
            r_action <= w_action;
            r_busy   <= (w_next != S_IDLE);
            r_ready  <= (w_next == S_IDLE);
            r_done   <= w_done;
            r_err    <= w_err;
            if (r_state == S_IDLE && i_cmd_valid) begin
                r_job_angle  <= i_cmd_angle;
                r_job_height <= w_cmd_h;
            end
        end
    end

    assign o_height_out  = r_height;
    assign o_action      = r_action;
    assign o_busy        = r_busy;
    assign o_cmd_ready   = r_ready;
    assign o_done        = r_done;
    assign o_err_timeout = r_err;

endmodule

// File: tb/tb_crane_ctrl_gen.sv
// Directed bench for crane_ctrl_gen: default instance plus an ANGLE_W=3 instance.
module tb_crane_ctrl_gen;

    logic       clk, reset;
    logic       cmd_valid, hooked, unhooked, abort;
    logic [1:0] cmd_angle;
    logic [2:0] cmd_height;
    logic       cmd_ready, busy, done, err_timeout;
    logic [1:0] angle_out;
    logic [2:0] height_out, action;

    logic       c3_valid, c3_abort, c3_ready, c3_busy, c3_done, c3_err;
    logic [2:0] c3_angle, c3_height, c3_angle_out, c3_height_out, c3_action;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_err_p  = 0;
    int base;
    int n;
    int cnt;

    crane_ctrl_gen u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_angle(cmd_angle), .i_cmd_height(cmd_height),
        .i_hooked(hooked), .i_unhooked(unhooked), .i_abort(abort),
        .o_angle_out(angle_out), .o_height_out(height_out), .o_action(action),
        .o_busy(busy), .o_done(done), .o_err_timeout(err_timeout)
    );

    crane_ctrl_gen #(.ANGLE_W(3)) u_dut3 (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(c3_valid), .o_cmd_ready(c3_ready),
        .i_cmd_angle(c3_angle), .i_cmd_height(c3_height),
        .i_hooked(1'b0), .i_unhooked(1'b0), .i_abort(c3_abort),
        .o_angle_out(c3_angle_out), .o_height_out(c3_height_out), .o_action(c3_action),
        .o_busy(c3_busy), .o_done(c3_done), .o_err_timeout(c3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (done)        n_done++;
        if (err_timeout) n_err_p++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_action(input logic [2:0] code, input int budget, output int cycles);
        cycles = 0;
        while (action !== code && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_angle = '0; cmd_height = '0;
        hooked = 1'b0; unhooked = 1'b0; abort = 1'b0;
        c3_valid = 1'b0; c3_angle = '0; c3_height = '0; c3_abort = 1'b0;
        #12;
        check("rst_angle",  32'(angle_out), 0);
        check("rst_height", 32'(height_out), 2);
        check("rst_action", 32'(action), 6);
        check("rst_busy",   32'(busy), 0);
        check("rst_ready",  32'(cmd_ready), 1);
        check("rst_done",   32'(done), 0);
        check("rst_err",    32'(err_timeout), 0);
        reset = 1'b0;
        tick();

        // Full pick cycle: angle 2, height 1
        base = n_done;
        cmd_valid = 1'b1; cmd_angle = 2'd2; cmd_height = 3'd1;
        tick();
        cmd_valid = 1'b0;
        check("a_turn_action", 32'(action), 7);
        check("a_busy",        32'(busy), 1);
        check("a_ready",       32'(cmd_ready), 0);
        ticks(2);  check("a_angle_hold", 32'(angle_out), 0);
        tick();    check("a_angle_1",    32'(angle_out), 1);
        ticks(3);  check("a_angle_2",    32'(angle_out), 2);
        tick();    check("a_lower",      32'(action), 0);
                   check("a_lower_h2",   32'(height_out), 2);
        tick();    check("a_lower_h1",   32'(height_out), 1);
        tick();    check("a_wait_hook",  32'(action), 1);
        tick();
        tick();    hooked = 1'b1;
        tick();    hooked = 1'b0;
                   check("a_raise",      32'(action), 2);
                   check("a_raise_h1",   32'(height_out), 1);
        tick();    check("a_raise_h2",   32'(height_out), 2);
        tick();    check("a_raise_h3",   32'(height_out), 3);
        tick();    check("a_wait_unhk",  32'(action), 3);
        tick();    unhooked = 1'b1;
        tick();    unhooked = 1'b0;
                   check("a_settle",     32'(action), 4);
                   check("a_settle_h3",  32'(height_out), 3);
        tick();    check("a_settle_h2",  32'(height_out), 2);
        tick();    check("a_r2",         32'(action), 5);
                   check("a_r2_angle",   32'(angle_out), 2);
        tick();    check("a_home_turn",  32'(action), 7);
        ticks(2);  check("a_home_3",     32'(angle_out), 3);
        ticks(3);  check("a_home_0",     32'(angle_out), 0);
        tick();    check("a_idle",       32'(action), 6);
                   check("a_done",       32'(done), 1);
                   check("a_idle_busy",  32'(busy), 0);
                   check("a_idle_ready", 32'(cmd_ready), 1);
        tick();    check("a_done_clr",   32'(done), 0);
        check("a_done_once", 32'(n_done - base), 1);

        // ANGLE_W=3 instance: 0 -> 7 by decrement, abort in LOWER, home by increment
        c3_valid = 1'b1; c3_angle = 3'd7; c3_height = 3'd2;
        tick();    c3_valid = 1'b0;
                   check("b_turn",       32'(c3_action), 7);
        ticks(2);  check("b_angle_hold", 32'(c3_angle_out), 0);
        tick();    check("b_angle_7",    32'(c3_angle_out), 7);
        tick();    check("b_lower",      32'(c3_action), 0);
                   c3_abort = 1'b1;
        tick();    c3_abort = 1'b0;
                   check("b_settle",     32'(c3_action), 4);
        tick();    check("b_r2",         32'(c3_action), 5);
        ticks(2);  check("b_home_hold",  32'(c3_angle_out), 7);
        tick();    check("b_home_0",     32'(c3_angle_out), 0);
        tick();    check("b_idle",       32'(c3_action), 6);
                   check("b_done",       32'(c3_done), 1);

        // WAIT_HOOK timeout, height 7 clamps to 3
        base = n_done;
        cmd_valid = 1'b1; cmd_angle = 2'd1; cmd_height = 3'd7;
        tick();    cmd_valid = 1'b0;
        wait_action(3'd1, 20, n);
        check("c_to_hook_cycles", n, 6);
        check("c_clamp_h",        32'(height_out), 3);
        cnt = n_err_p;
        wait_action(3'd4, 40, n);
        check("c_hook_timeout_cycles", n, 15);
        check("c_err_now",   32'(err_timeout), 1);
        check("c_err_count", 32'(n_err_p - cnt), 1);
        wait_action(3'd6, 20, n);
        check("c_home_cycles", n, 6);
        check("c_home_angle",  32'(angle_out), 0);
        check("c_done_once",   32'(n_done - base), 1);

        // WAIT_UNHOOK timeout: single pulse, holds, then resumes on unhooked
        base = n_done;
        cmd_valid = 1'b1; cmd_angle = 2'd0; cmd_height = 3'd1;
        tick();    cmd_valid = 1'b0;
        wait_action(3'd1, 20, n);
        check("d_to_hook_cycles", n, 3);
        hooked = 1'b1;
        tick();    hooked = 1'b0;
        wait_action(3'd3, 20, n);
        check("d_raise_cycles", n, 3);
        cnt = 0;
        base = n_err_p;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (action === 3'd3) cnt++;
        end
        check("d_hold_cycles",   cnt, 40);
        check("d_err_pulses",    32'(n_err_p - base), 1);
        check("d_hold_height",   32'(height_out), 3);
        base = n_done;
        unhooked = 1'b1;
        tick();    unhooked = 1'b0;
                   check("d_resume_settle", 32'(action), 4);
        wait_action(3'd6, 20, n);
        check("d_done_once", 32'(n_done - base), 1);

        // Abort during TURN_OUT at angle 1; cmd_valid while busy is not accepted
        base = n_done;
        cmd_valid = 1'b1; cmd_angle = 2'd2; cmd_height = 3'd1;
        tick();    cmd_angle = 2'd3;
                   check("e_ready_busy", 32'(cmd_ready), 0);
        ticks(3);  check("e_angle_1",    32'(angle_out), 1);
                   cmd_valid = 1'b0; abort = 1'b1;
        tick();    abort = 1'b0;
                   check("e_abort_settle", 32'(action), 4);
                   check("e_abort_angle",  32'(angle_out), 1);
        wait_action(3'd6, 20, n);
        check("e_home_cycles", n, 5);
        check("e_home_angle",  32'(angle_out), 0);
        check("e_done_once",   32'(n_done - base), 1);
        ticks(3);  check("e_no_queue",   32'(action), 6);
                   check("e_idle_busy",  32'(busy), 0);

        // Abort in RAISE is ignored, then async reset mid-RAISE
        cmd_valid = 1'b1; cmd_angle = 2'd1; cmd_height = 3'd1;
        tick();    cmd_valid = 1'b0;
        wait_action(3'd1, 20, n);
        check("f_to_hook_cycles", n, 6);
        hooked = 1'b1;
        tick();    hooked = 1'b0; abort = 1'b1;
                   check("f_raise_h1", 32'(height_out), 1);
        tick();    abort = 1'b0;
                   check("f_abort_ignored", 32'(action), 2);
                   check("f_raise_h2",      32'(height_out), 2);
        #2 reset = 1'b1;
        #1;
        check("g_rst_angle",  32'(angle_out), 0);
        check("g_rst_height", 32'(height_out), 2);
        check("g_rst_action", 32'(action), 6);
        check("g_rst_busy",   32'(busy), 0);
        #2 reset = 1'b0;
        tick();
        check("g_post_action", 32'(action), 6);
        check("g_post_ready",  32'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
